// File: rtl/regfile_np.sv
// regfile_np -- multi-read-port register file for the ID stage of the pipelined CPU.
//
// The storage is a DEPTH x WIDTH flop array with one synchronous write port.
// There are NUM_RD independent combinational read ports. Each read port is an
// AW-level tree of 2:1 muxes. Entry ZERO_REG, and any index >= DEPTH, always
// reads as zero. A write to either of those is dropped.
//
// Optional feature, selected by the macro REGFILE_WR_BYPASS_EN:
//   When the macro is defined, a valid write in the current cycle is forwarded
//   to every read port that addresses the same register. This lets a WB-stage
//   result reach an ID-stage read without waiting for the clock edge.
//   When the macro is undefined, reads only ever see the stored contents.
//   Storage behaviour is the same in both builds.
module regfile_np #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    // The mux tree works on a power-of-two leaf set. Leaves above DEPTH-1 are
    // tied to zero, which gives the out-of-range read rule for free.
    localparam int NLEAF = 1 << AW;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DEPTH < 2) begin : g_bad_depth
        $error("regfile_np: DEPTH (%0d) must be at least 2", DEPTH);
    end
    if (NUM_RD < 1) begin : g_bad_num_rd
        $error("regfile_np: NUM_RD (%0d) must be at least 1", NUM_RD);
    end
    if (ZERO_REG >= DEPTH || ZERO_REG < 0) begin : g_bad_zero_reg
        $error("regfile_np: ZERO_REG (%0d) must lie in 0..DEPTH-1 (%0d)", ZERO_REG, DEPTH - 1);
    end

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    // A write only counts when it targets a real, writable register. The
    // bypass path reuses this signal, so the two cannot disagree about which
    // writes are real.
    logic wr_hit;

    assign wr_hit = wr_en
                 && (int'(wr_addr) != ZERO_REG)
                 && (int'(wr_addr) <  DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    // Register array update: reset clears every entry and wins over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this is the only place that assigns sequential state. Using <=
            // makes every flop load the value it saw before the edge, so the
            // order of statements in the block does not matter.
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: the whole array is cleared because every read must return 0
                // after reset. A memory with a reset has to be built from flops,
                // not from a RAM macro.
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Leaf vector shared by all read ports
    // ------------------------------------------------------------------
    // ZERO_REG and the padding leaves are constant zero. Because of this,
    // ZERO_REG reads as 0 even before the first reset. Its flop is never
    // written, so it also never needs a read-side mask.
    logic [WIDTH-1:0] leaf [NLEAF];

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        if (i < DEPTH && i != ZERO_REG) begin : g_reg
            assign leaf[i] = mem[i];
        end else begin : g_zero
            assign leaf[i] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] tree [NLEAF];
        logic [WIDTH-1:0] data;

        assign addr = rd_addr[p*AW +: AW];

        // Mux tree: level l halves the candidate set using address bit l; the root ends up in tree[0].
        always_comb begin
            // NOTE: the array is fully loaded from the leaves first, so every
            // element has a value on every evaluation and no latch can be
            // inferred. It is then reduced in place: at level l, tree[j] only
            // reads tree[2j] and tree[2j+1], which have not yet been
            // overwritten during that level.
            for (int i = 0; i < NLEAF; i++) begin
                tree[i] = leaf[i];
            end
            for (int l = 0; l < AW; l++) begin
                for (int j = 0; j < (NLEAF >> (l + 1)); j++) begin
                    tree[j] = addr[l] ? tree[2*j + 1] : tree[2*j];
                end
            end
        end

`ifdef REGFILE_WR_BYPASS_EN
        // wr_hit already excludes ZERO_REG and out-of-range indices. So the
        // zero rule keeps priority over the bypass without a separate check.
        logic byp;

        assign byp  = wr_hit && !reset && (wr_addr == addr);
        assign data = byp ? wr_data : tree[0];
`else
        assign data = tree[0];
`endif

        assign rd_data[p*WIDTH +: WIDTH] = data;
    end

endmodule
